i8080_target_rx: RTL and testbench
==================================

// Module: i8080_target_rx
// PURPOSE
//  Target (LCD-side) end of the 16-bit 8080 parallel bus. Samples CS/WR/RD/RS/RESET from an external
//  host and decodes each WR strobe into a command word (RS=0) or a data word (RS=1).
//  Decoded words are queued in a show-ahead FIFO. RD strobes are answered from a user-supplied word.
//  Used as a panel model in verification and as a bridge when the FPGA acts as the display.
// PARAMETERS
//  DEPTH     16  FIFO entries; power of two, >=2
//  AW        4   log2(DEPTH)
// PORTS
//  clk            in   1    system clock (50 MHz nominal)
//  rst            in   1    synchronous, active-high reset
//  lcd_cs_n       in   1    bus chip select, active-low, asynchronous to clk
//  lcd_wr_n       in   1    write strobe; the word is latched on the rising edge
//  lcd_rd_n       in   1    read strobe; the target drives the bus while it is low
//  lcd_rs         in   1    0 = command, 1 = data
//  lcd_reset_n    in   1    host panel reset, active-low
//  lcd_data_in    in   16   bus input half
//  lcd_data_out   out  16   bus output half
//  lcd_data_oe    out  1    bus output enable (top level builds the tristate)
//  rx_valid       out  1    FIFO not empty
//  rx_ready       in   1    consumer accepts the head word
//  rx_is_data     out  1    RS bit of the head word
//  rx_word        out  16   head word
//  rd_word        in   16   value returned on the next bus read
//  rd_ack         out  1    1-cycle pulse when rd_word has been latched for a read
//  fifo_level     out  AW+1 current FIFO occupancy, 0..DEPTH
//  overflow       out  1    sticky: a write was dropped because the FIFO was full
//  proto_err      out  1    sticky: WR and RD were both low with CS low
// BEHAVIOUR
//  - Reset (rst=1): every output is 0, the FIFO is empty, the FSM is IDLE, and both sticky flags clear.
//  - Synchronizers: cs_n, wr_n, rd_n, rs, reset_n and data pass through 2 flops; data is delayed by
//    the same 2 flops, so a data word stays aligned with its strobe.
//  - Edge detection: compare sync stage 2 against a stage-3 copy. The stage-3 flops of the strobes
//    reset to 1.
//  - Host timing requirement: WR/RD low >=3 clk and high >=3 clk; data stable until 2 clk after WR rises.
//  - Write capture: WR rises with CS low -> push {rs,data} from the same sync stage. The push occurs
//    3 clk after the raw edge. If WR rises while CS is high, nothing is pushed.
//  - FIFO: show-ahead; rx_valid = level!=0; pop on rx_valid&&rx_ready.
//  - FIFO full: a push while full drops the word and sets overflow. If a push and a pop happen in the
//    same cycle while full, both succeed and overflow is not set. Pointers wrap modulo DEPTH.
//  - Read FSM: IDLE -> DRIVE on the falling edge of rd_n while CS is low.
//    - Entering DRIVE latches rd_word into lcd_data_out, sets lcd_data_oe=1 and pulses rd_ack once.
//    - DRIVE -> IDLE on the rising edge of rd_n or when CS goes high. oe drops in the cycle of exit.
//    - lcd_data_out holds its last value after exit.
//  - Conflict: WR and RD both low with CS low (sync) -> set proto_err. No push and no new read start.
//    An active DRIVE continues.
//  - Host reset: synced lcd_reset_n=0 has the same effect as rst, except that the synchronizers keep
//    running. Strobes are ignored until lcd_reset_n is high.
//  - Reset mid-read (rst or host reset): oe is 0 the next cycle; no rd_ack.
//  - Reset mid-write: no push.
// TESTING
//  - Write command 0x002C (RS=0), then data 0xF800 (RS=1), with rx_ready=1.
//    Expect rx_valid pulses carrying {0,0x002C} then {1,0xF800}; each appears 3-4 clk after its WR rise.
//  - Write 17 words with rx_ready=0 and DEPTH=16: fifo_level=16 and overflow=1, words 1..16 retained.
//    Then drain: the words come out in order and level returns to 0.
//  - With the FIFO full, a WR rise coincides with a pop: level stays 16, overflow stays 0, and the
//    new word ends up last.
//  - rd_word=0x9341, RD low for 6 clk: oe=1 from 3 clk after the fall, data_out=0x9341, a single
//    rd_ack pulse; oe=0 within 3 clk after the RD rise.
//  - WR and RD pulled low together with CS low: proto_err=1, no push, no rd_ack.
//  - lcd_reset_n low for 5 clk with 3 words queued: level returns to 0, flags clear, oe=0.
//    Normal writes resume after release.

Source files
------------

// File: rtl/i8080_target_rx.sv
// Target (panel-side) end of a 16-bit 8080 parallel bus: synchronizes the host strobes,
// queues written command/data words in a show-ahead FIFO and answers reads from i_rd_word.
module i8080_target_rx #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_lcd_cs_n,
  input  logic          i_lcd_wr_n,
  input  logic          i_lcd_rd_n,
  input  logic          i_lcd_rs,
  input  logic          i_lcd_reset_n,
  input  logic [15:0]   i_lcd_data_in,
  output logic [15:0]   o_lcd_data_out,
  output logic          o_lcd_data_oe,
  output logic          o_rx_valid,
  input  logic          i_rx_ready,
  output logic          o_rx_is_data,
  output logic [15:0]   o_rx_word,
  input  logic [15:0]   i_rd_word,
  output logic          o_rd_ack,
  output logic [AW:0]   o_fifo_level,
  output logic          o_overflow,
  output logic          o_proto_err
);

  localparam logic [AW:0] LP_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] LP_EMPTY = {(AW+1){1'b0}};

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_DRIVE = 1'b1} state_t;

  logic        r_cs_s1, r_cs_s2, r_rs_s1, r_rs_s2, r_hrst_s1, r_hrst_s2;
  logic        r_wr_s1, r_wr_s2, r_wr_s3, r_rd_s1, r_rd_s2, r_rd_s3;
  logic [15:0] r_data_s1, r_data_s2;

  logic [16:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_level;
  logic        r_overflow, r_wr_bad, r_proto_err, r_oe, r_ack;
  logic [15:0] r_dout;
  state_t      r_state, w_state_nxt;

  logic w_clr, w_conflict, w_wr_rise, w_rd_fall, w_rd_rise;
  logic w_push_req, w_push, w_pop, w_full, w_start;
  logic [16:0] w_head;

  // Two-flop synchronizers with a third stage on the strobes for edge detection
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cs_s1   <= 1'b1;  r_cs_s2   <= 1'b1;
      r_wr_s1   <= 1'b1;  r_wr_s2   <= 1'b1;  r_wr_s3 <= 1'b1;
      r_rd_s1   <= 1'b1;  r_rd_s2   <= 1'b1;  r_rd_s3 <= 1'b1;
      r_rs_s1   <= 1'b0;  r_rs_s2   <= 1'b0;
      r_hrst_s1 <= 1'b1;  r_hrst_s2 <= 1'b1;
      r_data_s1 <= 16'h0000;
      r_data_s2 <= 16'h0000;
    end else begin
      r_cs_s1   <= i_lcd_cs_n;    r_cs_s2   <= r_cs_s1;
      r_wr_s1   <= i_lcd_wr_n;    r_wr_s2   <= r_wr_s1;   r_wr_s3 <= r_wr_s2;
      r_rd_s1   <= i_lcd_rd_n;    r_rd_s2   <= r_rd_s1;   r_rd_s3 <= r_rd_s2;
      r_rs_s1   <= i_lcd_rs;      r_rs_s2   <= r_rs_s1;
      r_hrst_s1 <= i_lcd_reset_n; r_hrst_s2 <= r_hrst_s1;
      r_data_s1 <= i_lcd_data_in; r_data_s2 <= r_data_s1;
    end
  end

  assign w_clr      = i_rst | ~r_hrst_s2;
  assign w_conflict = ~r_cs_s2 & ~r_wr_s2 & ~r_rd_s2;
  assign w_wr_rise  = r_wr_s2 & ~r_wr_s3;
  assign w_rd_fall  = ~r_rd_s2 & r_rd_s3;
  assign w_rd_rise  = r_rd_s2 & ~r_rd_s3;

  // A write strobe that overlapped a WR/RD conflict is discarded on its rising edge
  assign w_push_req = w_wr_rise & ~r_cs_s2 & ~r_wr_bad;
  assign w_full     = (r_level == LP_FULL);
  assign w_pop      = (r_level != LP_EMPTY) & i_rx_ready;
  assign w_push     = w_push_req & (~w_full | w_pop);

  // FIFO pointers, occupancy and the write-side sticky state
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_wp       <= {AW{1'b0}};
      r_rp       <= {AW{1'b0}};
      r_level    <= LP_EMPTY;
      r_overflow <= 1'b0;
      r_wr_bad   <= 1'b0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1'b1);
      if (w_pop)  r_rp <= r_rp + AW'(1'b1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1'b1);
        2'b01:   r_level <= r_level - (AW+1)'(1'b1);
        default: r_level <= r_level;
      endcase
      if (w_push_req & w_full & ~w_pop) r_overflow <= 1'b1;
      if (w_conflict)     r_wr_bad <= 1'b1;
      else if (w_wr_rise) r_wr_bad <= 1'b0;
    end
  end

  // FIFO storage, {rs, data}
  always_ff @(posedge i_clk) begin
    if (w_push & ~w_clr) r_mem[r_wp] <= {r_rs_s2, r_data_s2};
  end

  assign w_head = (r_level != LP_EMPTY) ? r_mem[r_rp] : 17'h00000;

  // Read FSM next state; a conflict blocks a new read but not one already driving
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    if (w_clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rd_fall & ~r_cs_s2 & ~w_conflict) begin
            w_state_nxt = ST_DRIVE;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_DRIVE: begin
          if (w_rd_rise | r_cs_s2) w_state_nxt = ST_IDLE;
          else                     w_state_nxt = ST_DRIVE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Read FSM state register and registered bus-side outputs
  always_ff @(posedge i_clk) begin
    if (w_clr) begin
      r_state     <= ST_IDLE;
      r_oe        <= 1'b0;
      r_ack       <= 1'b0;
      r_dout      <= 16'h0000;
      r_proto_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_oe    <= (w_state_nxt == ST_DRIVE);
      r_ack   <= w_start;
      if (w_start)    r_dout      <= i_rd_word;
      if (w_conflict) r_proto_err <= 1'b1;
    end
  end

  assign o_lcd_data_out = r_dout;
  assign o_lcd_data_oe  = r_oe;
  assign o_rd_ack       = r_ack;
  assign o_rx_valid     = (r_level != LP_EMPTY);
  assign o_rx_is_data   = w_head[16];
  assign o_rx_word      = w_head[15:0];
  assign o_fifo_level   = r_level;
  assign o_overflow     = r_overflow;
  assign o_proto_err    = r_proto_err;

endmodule

// File: tb/tb_i8080_target_rx.sv
// Bench for i8080_target_rx: directed bus transactions with random payloads, checked
// against a queue-based model of the words the consumer must receive.
module tb_i8080_target_rx;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst, lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_reset_n;
  logic [15:0]   lcd_data_in, lcd_data_out, rx_word, rd_word;
  logic          lcd_data_oe, rx_valid, rx_ready, rx_is_data, rd_ack, overflow, proto_err;
  logic [AW:0]   fifo_level;

  int total = 0;
  int bad   = 0;
  int ack_cnt = 0;
  bit rand_rdy = 1'b0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  logic [16:0] words[$];

  i8080_target_rx #(.DEPTH(DEPTH), .AW(AW)) dut (
    .i_clk(clk), .i_rst(rst), .i_lcd_cs_n(lcd_cs_n), .i_lcd_wr_n(lcd_wr_n),
    .i_lcd_rd_n(lcd_rd_n), .i_lcd_rs(lcd_rs), .i_lcd_reset_n(lcd_reset_n),
    .i_lcd_data_in(lcd_data_in), .o_lcd_data_out(lcd_data_out), .o_lcd_data_oe(lcd_data_oe),
    .o_rx_valid(rx_valid), .i_rx_ready(rx_ready), .o_rx_is_data(rx_is_data),
    .o_rx_word(rx_word), .i_rd_word(rd_word), .o_rd_ack(rd_ack),
    .o_fifo_level(fifo_level), .o_overflow(overflow), .o_proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Consumer side: record every accepted head word and count read acknowledges
  always @(posedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back({rx_is_data, rx_word});
    if (rd_ack) ack_cnt <= ack_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) check(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic tick_rdy();
    @(negedge clk);
    if (rand_rdy) rx_ready = 1'($urandom_range(0, 1));
  endtask

  // mode 0: plain write; 1: check valid latency; 2: pop exactly in the push cycle
  task automatic bus_write(input logic rs, input logic [15:0] d, input int mode);
    @(negedge clk);
    lcd_rs = rs; lcd_data_in = d; lcd_wr_n = 1'b0;
    repeat (4) tick_rdy();
    lcd_wr_n = 1'b1;
    if (mode == 1) begin
      @(negedge clk);
      @(negedge clk);
      check("latency_early", 32'(rx_valid), 32'd0);
      @(negedge clk);
      check("latency_valid", 32'(rx_valid), 32'd1);
      check("latency_word", 32'({rx_is_data, rx_word}), 32'({rs, d}));
      @(negedge clk);
    end else if (mode == 2) begin
      @(negedge clk);
      @(negedge clk);
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      @(negedge clk);
    end else begin
      repeat (4) tick_rdy();
    end
  endtask

  initial begin
    logic [16:0] w;
    rst = 1'b1; lcd_cs_n = 1'b1; lcd_wr_n = 1'b1; lcd_rd_n = 1'b1; lcd_rs = 1'b0;
    lcd_reset_n = 1'b1; lcd_data_in = 16'h0000; rx_ready = 1'b0; rd_word = 16'h0000;
    repeat (4) @(negedge clk);
    check("reset_outputs", {lcd_data_out, rx_word, 4'(fifo_level), 1'(lcd_data_oe), 1'(rx_valid),
          1'(rx_is_data), 1'(rd_ack), 1'(overflow), 1'(proto_err)}, 32'd0);
    rst = 1'b0;
    lcd_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_level", 32'(fifo_level), 32'd0);

    // command then data, consumer always ready
    rx_ready = 1'b1;
    bus_write(1'b0, 16'h002C, 1); exp_q.push_back({1'b0, 16'h002C});
    bus_write(1'b1, 16'hF800, 1); exp_q.push_back({1'b1, 16'hF800});
    repeat (4) @(negedge clk);
    check_stream("cmd_data");

    // random words with a randomly stalling consumer (never more than DEPTH in flight)
    rand_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w = 17'($urandom);
      bus_write(w[16], w[15:0], 0);
      exp_q.push_back(w);
    end
    rand_rdy = 1'b0; rx_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("random_drained", 32'(fifo_level), 32'd0);
    check_stream("random_order");

    // write while CS is high: ignored
    lcd_cs_n = 1'b1;
    bus_write(1'b1, 16'h1234, 0);
    repeat (3) @(negedge clk);
    check("cs_high_ignored", 32'(rx_valid), 32'd0);
    lcd_cs_n = 1'b0;

    // overflow: 17 writes into a stalled consumer, the model keeps the first DEPTH
    rx_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      w = 17'($urandom);
      bus_write(w[16], w[15:0], 0);
      if (i < DEPTH) exp_q.push_back(w);
    end
    check("ovf_level", 32'(fifo_level), 32'(DEPTH));
    check("ovf_flag", 32'(overflow), 32'd1);
    rx_ready = 1'b1;
    repeat (20) @(negedge clk);
    check("ovf_drain_level", 32'(fifo_level), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    check_stream("ovf_order");

    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_clears_ovf", 32'(overflow), 32'd0);

    // full FIFO: a push coinciding with a pop is accepted and lands last
    rx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w = 17'($urandom);
      bus_write(w[16], w[15:0], 0);
      exp_q.push_back(w);
    end
    check("full_level", 32'(fifo_level), 32'(DEPTH));
    w = 17'($urandom);
    bus_write(w[16], w[15:0], 2);
    exp_q.push_back(w);
    check("coincide_level", 32'(fifo_level), 32'(DEPTH));
    check("coincide_no_ovf", 32'(overflow), 32'd0);
    rx_ready = 1'b1;
    repeat (20) @(negedge clk);
    check_stream("coincide_order");

    // bus read
    ack_cnt = 0;
    rd_word = 16'h9341;
    lcd_rd_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rd_oe_early", 32'(lcd_data_oe), 32'd0);
    @(negedge clk);
    check("rd_oe_on", 32'(lcd_data_oe), 32'd1);
    check("rd_data", 32'(lcd_data_out), 32'h9341);
    check("rd_ack_pulse", 32'(rd_ack), 32'd1);
    repeat (3) @(negedge clk);
    lcd_rd_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rd_oe_off", 32'(lcd_data_oe), 32'd0);
    check("rd_data_hold", 32'(lcd_data_out), 32'h9341);
    check("rd_ack_count", 32'(ack_cnt), 32'd1);

    // WR and RD low together
    ack_cnt = 0;
    lcd_wr_n = 1'b0; lcd_rd_n = 1'b0; lcd_data_in = 16'hDEAD;
    repeat (5) @(negedge clk);
    lcd_wr_n = 1'b1; lcd_rd_n = 1'b1;
    repeat (6) @(negedge clk);
    check("conflict_err", 32'(proto_err), 32'd1);
    check("conflict_no_push", 32'(fifo_level), 32'd0);
    check("conflict_no_ack", 32'(ack_cnt), 32'd0);
    check("conflict_no_oe", 32'(lcd_data_oe), 32'd0);

    // host reset with words queued and a read in progress
    rx_ready = 1'b0;
    for (int i = 0; i < 3; i++) bus_write(1'b1, 16'($urandom), 0);
    check("hrst_queued", 32'(fifo_level), 32'd3);
    lcd_rd_n = 1'b0;
    repeat (5) @(negedge clk);
    check("hrst_read_oe", 32'(lcd_data_oe), 32'd1);
    ack_cnt = 0;
    lcd_reset_n = 1'b0;
    repeat (5) @(negedge clk);
    check("hrst_level", 32'(fifo_level), 32'd0);
    check("hrst_flags", {30'd0, overflow, proto_err}, 32'd0);
    check("hrst_oe", 32'(lcd_data_oe), 32'd0);
    lcd_rd_n = 1'b1;
    repeat (3) @(negedge clk);
    lcd_reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("hrst_no_ack", 32'(ack_cnt), 32'd0);
    check("hrst_oe_after", 32'(lcd_data_oe), 32'd0);
    got_q.delete();
    rx_ready = 1'b1;
    w = 17'($urandom);
    bus_write(w[16], w[15:0], 0);
    exp_q.push_back(w);
    repeat (4) @(negedge clk);
    check_stream("hrst_resume");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
